// File: rtl/gcd_share_ctrl.sv
// ============================================================================
// gcd_share_ctrl : round-robin sharing of one GCD core among NUM_REQ requesters
// Optional watchdog: define GCD_ARB_TIMEOUT_EN.           Revision: 1.0
// ============================================================================
`default_nettype none

module gcd_share_ctrl #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] op_a_i,
   input  logic [NUM_REQ*DATA_W-1:0] op_b_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_data_o,
   output logic                      rsp_err_o,
   output logic                      busy_o,
   output logic                      core_start_o,
   output logic [DATA_W-1:0]         core_a_o,
   output logic [DATA_W-1:0]         core_b_o,
   output logic                      core_abort_o,
   input  logic                      core_done_i,
   input  logic [DATA_W-1:0]         core_result_i
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("gcd_share_ctrl: unsupported parameter set");
   end

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  winner_q, winner_d;
   logic [DATA_W-1:0] core_a_q, core_a_d;
   logic [DATA_W-1:0] core_b_q, core_b_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic [DATA_W-1:0] win_a, win_b;

`ifdef GCD_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            rsp_err_q, rsp_err_d;
   logic            wd_expired;

   // core_done in the expiry cycle takes priority over the abort
   assign wd_expired = (state_q == S_WAIT) && !core_done_i &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign rsp_err_o  = rsp_err_q;
`else
   assign rsp_err_o  = 1'b0;
`endif

   // First set request at or after rr_ptr, wrapping around
   always_comb begin : p_arb
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!win_found && req_i[idx]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(idx);
         end
      end
   end

   assign win_a = op_a_i[int'(win_idx)*DATA_W +: DATA_W];
   assign win_b = op_b_i[int'(win_idx)*DATA_W +: DATA_W];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         winner_q   <= '0;
         core_a_q   <= '0;
         core_b_q   <= '0;
         rsp_data_q <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
         wd_q       <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         winner_q   <= winner_d;
         core_a_q   <= core_a_d;
         core_b_q   <= core_b_d;
         rsp_data_q <= rsp_data_d;
`ifdef GCD_ARB_TIMEOUT_EN
         wd_q       <= wd_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      winner_d   = winner_q;
      core_a_d   = core_a_q;
      core_b_d   = core_b_q;
      rsp_data_d = rsp_data_q;
`ifdef GCD_ARB_TIMEOUT_EN
      wd_d       = '0;
      rsp_err_d  = rsp_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               winner_d = win_idx;
               core_a_d = win_a;
               core_b_d = win_b;
`ifdef GCD_ARB_TIMEOUT_EN
               rsp_err_d = 1'b0;
`endif
               // gcd(x,0) = gcd(0,x) = x, so a|b covers every zero case
               if (win_a == '0 || win_b == '0) begin
                  rsp_data_d = win_a | win_b;
                  state_d    = S_RESP;
               end else begin
                  state_d    = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (core_done_i) begin
               rsp_data_d = core_result_i;
               state_d    = S_RESP;
`ifdef GCD_ARB_TIMEOUT_EN
            end else if (wd_expired) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end else begin
               wd_d = wd_q + WD_W'(1);
`endif
            end
         end
         S_RESP: begin
            rr_ptr_d = (winner_q == C_LAST_IDX) ? '0 : winner_q + IDX_W'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // gnt is decided combinationally in IDLE; masked while reset is held
   always_comb begin
      gnt_o        = '0;
      rsp_valid_o  = '0;
      core_start_o = 1'b0;
      core_abort_o = 1'b0;
      case (state_q)
         S_IDLE:  if (win_found && sys_rst_n) gnt_o[win_idx] = 1'b1;
         S_ISSUE: core_start_o = 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
         S_WAIT:  core_abort_o = wd_expired;
`endif
         S_RESP:  rsp_valid_o[winner_q] = 1'b1;
         default: ;
      endcase
   end

   assign busy_o     = (state_q != S_IDLE);
   assign rsp_data_o = rsp_data_q;
   assign core_a_o   = core_a_q;
   assign core_b_o   = core_b_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_share_ctrl.sv
// Scoreboard bench for gcd_share_ctrl with a behavioural GCD core model.
// Timeout scenarios are included when GCD_ARB_TIMEOUT_EN is defined.
`default_nettype none

module tb_gcd_share_ctrl;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int TMO = 16;
`ifdef GCD_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic           sys_clk = 1'b0;
   logic           sys_rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] op_a = '0, op_b = '0;
   logic           core_done = 1'b0;
   logic [W-1:0]   core_result = '0;

   logic [N-1:0]   gnt_o, rsp_valid_o;
   logic [W-1:0]   rsp_data_o, core_a_o, core_b_o;
   logic           rsp_err_o, busy_o, core_start_o, core_abort_o;

   gcd_share_ctrl #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req_i(req), .op_a_i(op_a), .op_b_i(op_b),
      .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .rsp_err_o(rsp_err_o), .busy_o(busy_o), .core_start_o(core_start_o),
      .core_a_o(core_a_o), .core_b_o(core_b_o), .core_abort_o(core_abort_o),
      .core_done_i(core_done), .core_result_i(core_result)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0, n_fail = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a; y = b;
      while (y != 0) begin
         t = x % y; x = y; y = t;
      end
      return x;
   endfunction

   typedef struct {
      int           idx;
      logic [W-1:0] data;
      logic         err;
      logic         zero;
   } exp_t;

   exp_t         sb[$];
   int           grant_log[$];
   logic [W-1:0] a_of[N], b_of[N];
   int           ptr_m = 0;
   int           core_mode = 0;   // 0: random delay, 1: fixed_delay, 2: never done
   int           fixed_delay = 10;
   int           gnt_cyc = 0, done_cyc = 0, start_cyc = 0;
   int           n_starts = 0, n_aborts = 0, exp_aborts = 0;
   logic [W-1:0] last_a = '0, last_b = '0;
   logic         last_nonzero = 1'b0;
   int           core_cnt = 0;

   // Behavioural GCD core: answers gcd(a,b) a chosen number of cycles after start
   initial begin : core_model
      logic [W-1:0] ca, cb;
      ca = '0; cb = '0;
      forever begin
         @(negedge sys_clk);
         core_done = 1'b0;
         if (core_abort_o) core_cnt = 0;
         if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               core_done   = 1'b1;
               core_result = ref_gcd(ca, cb);
               done_cyc    = cyc;
            end
         end
         if (core_start_o) begin
            ca = core_a_o; cb = core_b_o;
            core_cnt = (core_mode == 2) ? 0 :
                       (core_mode == 1) ? fixed_delay : int'($urandom_range(1, 12));
         end
      end
   end

   // Monitor: predicts grants from the requester set, checks every response
   initial begin : monitor
      exp_t         e;
      logic [N-1:0] eg;
      int           w;
      logic         tmo;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n) begin
            if (gnt_o != '0) begin
               w = -1;
               for (int k = 0; k < N; k++)
                  if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
               eg = '0;
               if (w >= 0) eg[w] = 1'b1;
               check("gnt_winner", gnt_o, eg);
               if (w >= 0) begin
                  ptr_m = (w + 1) % N;
                  grant_log.push_back(w);
                  gnt_cyc      = cyc;
                  last_a       = a_of[w];
                  last_b       = b_of[w];
                  last_nonzero = (a_of[w] != 0) && (b_of[w] != 0);
                  tmo = TMO_EN && last_nonzero &&
                        (core_mode == 2 || (core_mode == 1 && fixed_delay > TMO));
                  e.idx  = w;
                  e.zero = !last_nonzero;
                  e.err  = tmo;
                  e.data = tmo ? '0 : ref_gcd(a_of[w], b_of[w]);
                  if (tmo) exp_aborts++;
                  sb.push_back(e);
               end
            end
            if (core_start_o) begin
               n_starts++;
               start_cyc = cyc;
               check("start_only_nonzero", last_nonzero, 1'b1);
               check("core_a", core_a_o, last_a);
               check("core_b", core_b_o, last_b);
            end
            if (core_abort_o) begin
               n_aborts++;
               check("abort_latency", cyc - start_cyc, TMO);
            end
            if (rsp_valid_o != '0) begin
               if (sb.size() == 0) begin
                  check("rsp_unexpected", rsp_valid_o, '0);
               end else begin
                  e  = sb.pop_front();
                  eg = '0;
                  eg[e.idx] = 1'b1;
                  check("rsp_valid", rsp_valid_o, eg);
                  check("rsp_data", rsp_data_o, e.data);
                  check("rsp_err", rsp_err_o, e.err);
                  if (e.zero) check("zero_latency", cyc - gnt_cyc, 1);
                  else if (!e.err) check("done_to_rsp", cyc - done_cyc, 1);
                  req[e.idx] = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_of[i] = a; b_of[i] = b;
      op_a[i*W +: W] = a;
      op_b[i*W +: W] = b;
      req[i] = 1'b1;
   endtask

   task automatic drain(input int max_cyc);
      for (int c = 0; c < max_cyc; c++) begin
         tick();
         if (req == '0 && sb.size() == 0 && !busy_o) return;
      end
      check("drain_timeout", {req, busy_o}, '0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, {gnt_o, rsp_valid_o, busy_o, core_start_o, core_abort_o, rsp_err_o}, '0);
      check({tag, "_data"}, {rsp_data_o, core_a_o}, '0);
      check({tag, "_core_b"}, core_b_o, '0);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      req = '0;
      sb.delete();
      ptr_m = 0;
      repeat (3) tick();
      check_quiet("reset");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin : stimulus
      int s0, g;
      do_reset();

      // Single job 48,18 -> 6 after 10 core cycles
      core_mode = 1; fixed_delay = 10;
      tick(); issue(0, 48, 18);
      drain(100);
      check("single_starts", n_starts, 1);

      // All four requesting, two rounds, from a fresh pointer
      do_reset();
      core_mode = 0;
      grant_log.delete();
      for (int r = 0; r < 2; r++) begin
         tick();
         for (int i = 0; i < N; i++) issue(i, 12 * (i + 3), 18 * (i + 1));
         drain(200);
      end
      check("rr_grant_count", grant_log.size(), 2 * N);
      for (int k = 0; k < grant_log.size(); k++) check("rr_order", grant_log[k], k % N);

      // Zero operands are answered without the core
      s0 = n_starts;
      tick(); issue(2, 0, 25); drain(20);
      tick(); issue(2, 0, 0);  drain(20);
      tick(); issue(1, 7, 0);  drain(20);
      check("zero_no_start", n_starts, s0);

      // Randomized traffic
      core_mode = 0;
      for (int it = 0; it < 80; it++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               g = $urandom_range(1, 1000);
               issue(i, W'(g * $urandom_range(0, 60)), W'(g * $urandom_range(0, 60)));
            end
         end
      end
      drain(2000);

      // Asynchronous reset in the middle of WAIT, then a stale core_done
      core_mode = 1; fixed_delay = 20;
      tick(); issue(3, 90, 60);
      repeat (8) tick();
      check("pre_reset_busy", busy_o, 1'b1);
      #2 sys_rst_n = 1'b0;
      req = '0;
      sb.delete();
      ptr_m = 0;
      #1 check_quiet("async_reset");
      repeat (2) tick();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (25) tick();
      check("stale_done_ignored", busy_o, 1'b0);
      core_mode = 0;
      tick(); issue(1, 35, 21);
      drain(100);

`ifdef GCD_ARB_TIMEOUT_EN
      core_mode = 2;
      tick(); issue(0, 12, 8); drain(100);
      check("abort_after_hang", n_aborts, 1);
      core_mode = 1; fixed_delay = TMO;
      tick(); issue(1, 12, 8); drain(100);
      check("done_at_limit_no_abort", n_aborts, 1);
      fixed_delay = TMO + 1;
      tick(); issue(2, 21, 14); drain(100);
      check("abort_past_limit", n_aborts, 2);
      core_mode = 0;
      tick(); issue(3, 21, 14); drain(100);
`endif

      check("aborts_total", n_aborts, exp_aborts);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
